// File: rtl/qdr_reset_sequencer_pkg.sv
// Shared definitions for the QDR reset/calibration sequencer.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
package qdr_reset_sequencer_pkg;

   // Width of the shared reset/calibration cycle counter.
   localparam int QDR_CNT_W = 24;

   typedef enum logic [1:0] {
      QDR_SEQ_RESET    = 2'd0,
      QDR_SEQ_WAIT_CAL = 2'd1,
      QDR_SEQ_READY    = 2'd2,
      QDR_SEQ_FAILED   = 2'd3
   } qdr_seq_state_t;

   // The sequence counts as in progress while the PHY is in reset or calibrating.
   function automatic logic qdr_seq_busy(input qdr_seq_state_t s);
      return (s == QDR_SEQ_RESET) || (s == QDR_SEQ_WAIT_CAL);
   endfunction

endpackage

// File: rtl/qdr_sync_2ff.sv
// Two-flop level synchroniser with synchronous clear.
// Latency: 2 wb_clk_i cycles from async_in to sync_out.
// Backpressure: none; samples every cycle.
// Ports: wb_clk_i clock, sync_clr synchronous clear (both flops), async_in
//        level from a foreign domain, sync_out synchronised level.
module qdr_sync_2ff (
   input  logic wb_clk_i,
   input  logic sync_clr,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   always_ff @(posedge wb_clk_i) begin
      if (sync_clr) begin
         meta     <= 1'b0;
         sync_out <= 1'b0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/qdr_reset_sequencer.sv
// QDR PHY reset and calibration sequencer with timeout and bounded retries.
// Latency: outputs registered; phy_ready follows phy_cal_done by 3 cycles, phy_reset follows qdr_reset_req by 1.
// Backpressure: none; the restart strobe and PHY status are consumed every cycle.
// Ports: wb_clk_i/wb_rst_i clock and sync active-high reset; qdr_reset_req restart
//        strobe; phy_cal_done/phy_cal_fail async PHY status; phy_reset, phy_ready,
//        cal_fail, retry_count, seq_busy registered control/status outputs.
module qdr_reset_sequencer
   import qdr_reset_sequencer_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = 64,
   parameter int unsigned CAL_TIMEOUT  = 1000000,
   parameter int unsigned MAX_RETRIES  = 3
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       qdr_reset_req,
   input  logic       phy_cal_done,
   input  logic       phy_cal_fail,
   output logic       phy_reset,
   output logic       phy_ready,
   output logic       cal_fail,
   output logic [1:0] retry_count,
   output logic       seq_busy
);

   localparam logic [QDR_CNT_W-1:0] RST_LAST = QDR_CNT_W'(RESET_CYCLES - 1);
   localparam logic [QDR_CNT_W-1:0] CAL_LAST = QDR_CNT_W'(CAL_TIMEOUT - 1);
   localparam logic [1:0]           MAX_R    = 2'(MAX_RETRIES);

   qdr_seq_state_t       state_q, state_d;
   logic [QDR_CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]           retry_q, retry_d;
   logic                 done_s, fail_s;
   logic                 attempt_fail;
   logic                 phy_reset_d, phy_ready_d, cal_fail_d, seq_busy_d;

   qdr_sync_2ff u_sync_done (
      .wb_clk_i (wb_clk_i),
      .sync_clr (wb_rst_i),
      .async_in (phy_cal_done),
      .sync_out (done_s)
   );

   qdr_sync_2ff u_sync_fail (
      .wb_clk_i (wb_clk_i),
      .sync_clr (wb_rst_i),
      .async_in (phy_cal_fail),
      .sync_out (fail_s)
   );

   // State, counter and retry register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= QDR_SEQ_RESET;
         cnt_q   <= '0;
         retry_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
      end
   end

   // Next-state logic. The restart strobe is applied last so it overrides
   // any same-cycle done, fail or timeout outcome.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + 24'd1;
      retry_d      = retry_q;
      attempt_fail = 1'b0;
      case (state_q)
         QDR_SEQ_RESET: begin
            if (cnt_q == RST_LAST) begin
               state_d = QDR_SEQ_WAIT_CAL;
               cnt_d   = '0;
            end
         end
         QDR_SEQ_WAIT_CAL: begin
            if (fail_s) begin
               attempt_fail = 1'b1;
            end else if (done_s) begin
               state_d = QDR_SEQ_READY;
               cnt_d   = '0;
            end else if (cnt_q == CAL_LAST) begin
               attempt_fail = 1'b1;
            end
         end
         QDR_SEQ_READY: begin
            cnt_d = '0;
            // Calibration lost: restart the whole sequence with a fresh retry budget.
            if (!done_s) begin
               state_d = QDR_SEQ_RESET;
               retry_d = '0;
            end
         end
         QDR_SEQ_FAILED: begin
            cnt_d = '0;
         end
      endcase

      if (attempt_fail) begin
         cnt_d = '0;
         if (retry_q < MAX_R) begin
            retry_d = retry_q + 2'd1;
            state_d = QDR_SEQ_RESET;
         end else begin
            state_d = QDR_SEQ_FAILED;
         end
      end

      if (qdr_reset_req) begin
         state_d = QDR_SEQ_RESET;
         cnt_d   = '0;
         retry_d = '0;
      end
   end

   // Output decode from the next state, so the registered outputs line up
   // with the state they describe.
   always_comb begin
      phy_reset_d = (state_d == QDR_SEQ_RESET);
      phy_ready_d = (state_d == QDR_SEQ_READY);
      cal_fail_d  = (state_d == QDR_SEQ_FAILED);
      seq_busy_d  = qdr_seq_busy(state_d);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         phy_reset <= 1'b1;
         phy_ready <= 1'b0;
         cal_fail  <= 1'b0;
         seq_busy  <= 1'b1;
      end else begin
         phy_reset <= phy_reset_d;
         phy_ready <= phy_ready_d;
         cal_fail  <= cal_fail_d;
         seq_busy  <= seq_busy_d;
      end
   end

   assign retry_count = retry_q;

endmodule

// File: tb/tb_qdr_reset_sequencer.sv
// Self-checking bench for qdr_reset_sequencer: directed phases plus random stimulus,
// all outputs compared each cycle against a phase/elapsed-time model.
// Clock period 10 ns; inputs change on the falling edge.
module tb_qdr_reset_sequencer;

   localparam int RC = 8;
   localparam int CT = 100;
   localparam int MR = 2;
   localparam int HMAX = 16384;

   localparam int PH_RESET  = 0;
   localparam int PH_WAIT   = 1;
   localparam int PH_READY  = 2;
   localparam int PH_FAILED = 3;

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i = 1'b1;
   logic       qdr_reset_req = 1'b0;
   logic       phy_cal_done = 1'b0;
   logic       phy_cal_fail = 1'b0;
   logic       phy_reset;
   logic       phy_ready;
   logic       cal_fail;
   logic [1:0] retry_count;
   logic       seq_busy;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   // Model state: which phase, how many cycles already spent in it, failed attempts.
   int ph = PH_RESET;
   int spent = 0;
   int fails = 0;
   int edge_n = 0;
   bit rst_h  [HMAX];
   bit done_h [HMAX];
   bit fail_h [HMAX];

   always #5 wb_clk_i = ~wb_clk_i;

   qdr_reset_sequencer #(
      .RESET_CYCLES (RC),
      .CAL_TIMEOUT  (CT),
      .MAX_RETRIES  (MR)
   ) dut (
      .wb_clk_i      (wb_clk_i),
      .wb_rst_i      (wb_rst_i),
      .qdr_reset_req (qdr_reset_req),
      .phy_cal_done  (phy_cal_done),
      .phy_cal_fail  (phy_cal_fail),
      .phy_reset     (phy_reset),
      .phy_ready     (phy_ready),
      .cal_fail      (cal_fail),
      .retry_count   (retry_count),
      .seq_busy      (seq_busy)
   );

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic attempt_failed();
      spent = 0;
      if (fails < MR) begin
         fails++;
         ph = PH_RESET;
      end else begin
         ph = PH_FAILED;
      end
   endtask

   // Behavioural model, advanced once per rising edge from the inputs sampled there.
   // The sequencer sees PHY status as it was two edges earlier, or 0 if either of
   // the two intervening edges was a reset edge.
   task automatic model_step();
      bit ds, fs;
      edge_n++;
      if (edge_n < HMAX) begin
         rst_h[edge_n]  = wb_rst_i;
         done_h[edge_n] = phy_cal_done;
         fail_h[edge_n] = phy_cal_fail;
      end
      ds = 1'b0;
      fs = 1'b0;
      if (edge_n >= 2 && edge_n < HMAX) begin
         if (!rst_h[edge_n-1] && !rst_h[edge_n-2]) begin
            ds = done_h[edge_n-2];
            fs = fail_h[edge_n-2];
         end
      end
      if (wb_rst_i || qdr_reset_req) begin
         ph = PH_RESET;
         spent = 0;
         fails = 0;
      end else begin
         case (ph)
            PH_RESET: begin
               if (spent + 1 == RC) begin
                  ph = PH_WAIT;
                  spent = 0;
               end else begin
                  spent++;
               end
            end
            PH_WAIT: begin
               if (fs || (!ds && spent + 1 == CT)) attempt_failed();
               else if (ds) begin
                  ph = PH_READY;
                  spent = 0;
               end else spent++;
            end
            PH_READY: begin
               if (!ds) begin
                  ph = PH_RESET;
                  spent = 0;
                  fails = 0;
               end
            end
            default: ;
         endcase
      end
   endtask

   always @(posedge wb_clk_i) model_step();

   // Per-cycle comparison of every output against the model.
   always @(negedge wb_clk_i) begin
      if (chk_en) begin
         check("phy_reset",   phy_reset,   (ph == PH_RESET) ? 1 : 0);
         check("phy_ready",   phy_ready,   (ph == PH_READY) ? 1 : 0);
         check("cal_fail",    cal_fail,    (ph == PH_FAILED) ? 1 : 0);
         check("seq_busy",    seq_busy,    (ph == PH_RESET || ph == PH_WAIT) ? 1 : 0);
         check("retry_count", retry_count, fails);
      end
   end

   function automatic logic sel(input int which);
      case (which)
         0:       return phy_reset;
         1:       return phy_ready;
         2:       return cal_fail;
         default: return seq_busy;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge wb_clk_i);
   endtask

   // Bounded wait for an output level; k = falling edges waited.
   task automatic wait_sig(input string name, input int which, input logic val,
                           input int bound, output int k);
      k = 0;
      do begin
         @(negedge wb_clk_i);
         k++;
      end while (sel(which) != val && k < bound);
      check(name, sel(which), val);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      tick(3);
      chk_en = 1'b1;
      check("rst_phy_reset", phy_reset, 1);
      check("rst_phy_ready", phy_ready, 0);
      check("rst_cal_fail",  cal_fail,  0);
      check("rst_seq_busy",  seq_busy,  1);
      check("rst_retry",     retry_count, 0);

      // Release reset, calibrate 20 cycles into the wait.
      wb_rst_i = 1'b0;
      wait_sig("wait_reset_low", 0, 1'b0, 50, k);
      check("reset_len_release", k, RC);
      tick(19);
      phy_cal_done = 1'b1;
      wait_sig("wait_ready", 1, 1'b1, 10, k);
      check("ready_latency", k, 3);
      check("ready_retry", retry_count, 0);
      check("ready_busy", seq_busy, 0);

      // Calibration loss and recovery.
      tick(5);
      phy_cal_done = 1'b0;
      wait_sig("wait_ready_loss", 1, 1'b0, 10, k);
      check("loss_latency", k, 3);
      check("loss_phy_reset", phy_reset, 1);
      check("loss_retry", retry_count, 0);
      wait_sig("wait_recal", 0, 1'b0, 20, k);
      tick($urandom_range(1, 30));
      phy_cal_done = 1'b1;
      wait_sig("wait_ready2", 1, 1'b1, 10, k);
      check("ready_latency2", k, 3);

      // Fail and done together in the calibration wait: counts as a failure.
      tick(3);
      phy_cal_done = 1'b0;
      wait_sig("wait_reset_hi", 0, 1'b1, 10, k);
      wait_sig("wait_cal_phase", 0, 1'b0, 20, k);
      tick($urandom_range(1, 50));
      phy_cal_done = 1'b1;
      phy_cal_fail = 1'b1;
      tick(1);
      phy_cal_done = 1'b0;
      phy_cal_fail = 1'b0;
      wait_sig("wait_fail_retry", 0, 1'b1, 10, k);
      check("fail_prio_latency", k, 2);
      check("fail_prio_retry", retry_count, 1);
      check("fail_prio_ready", phy_ready, 0);

      // Restart from scratch, then let every attempt time out.
      qdr_reset_req = 1'b1;
      tick(1);
      qdr_reset_req = 1'b0;
      check("req_phy_reset", phy_reset, 1);
      check("req_retry", retry_count, 0);
      wait_sig("wait_exhaust", 2, 1'b1, 500, k);
      check("exhaust_time", k, 3 * (RC + CT));
      check("exhaust_retry", retry_count, MR);
      check("exhaust_phy_reset", phy_reset, 0);
      check("exhaust_busy", seq_busy, 0);
      tick(30);
      check("cal_fail_sticky", cal_fail, 1);

      // Restart out of the failed state.
      qdr_reset_req = 1'b1;
      tick(1);
      qdr_reset_req = 1'b0;
      check("unfail_phy_reset", phy_reset, 1);
      check("unfail_cal_fail", cal_fail, 0);
      check("unfail_retry", retry_count, 0);

      // Restart strobe on the very edge the final attempt times out.
      tick(3 * (RC + CT) - 1);
      qdr_reset_req = 1'b1;
      tick(1);
      qdr_reset_req = 1'b0;
      check("race_phy_reset", phy_reset, 1);
      check("race_cal_fail", cal_fail, 0);
      check("race_retry", retry_count, 0);
      tick(40);
      check("race_no_cal_fail", cal_fail, 0);

      // Reset in the middle of the calibration wait.
      wait_sig("wait_cal_phase2", 0, 1'b0, 20, k);
      tick($urandom_range(5, 30));
      wb_rst_i = 1'b1;
      tick(1);
      check("midrst_phy_reset", phy_reset, 1);
      check("midrst_phy_ready", phy_ready, 0);
      check("midrst_cal_fail",  cal_fail,  0);
      check("midrst_seq_busy",  seq_busy,  1);
      check("midrst_retry",     retry_count, 0);
      wb_rst_i = 1'b0;

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge wb_clk_i);
         if ($urandom_range(0, 59) == 0) phy_cal_done = ~phy_cal_done;
         phy_cal_fail  = ($urandom_range(0, 249) == 0);
         qdr_reset_req = ($urandom_range(0, 399) == 0);
         wb_rst_i      = ($urandom_range(0, 1499) == 0);
      end
      @(negedge wb_clk_i);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
